jpeg_frame_sequencer: RTL and testbench

- Top-level frame scheduler for the OV7670 -> JPEG encoder -> ESP32 SPI pipeline.
- On an ESP32 frame request it arms capture on the next camera VSYNC, starts the encoder when capture completes, and releases the JPEG buffer to the SPI readout path.
- It holds the buffer until the readout path reports EOF, then counts the frame.
- Supervises every wait with a timeout; supports abort and a free-running continuous mode.

---
 rtl/jpeg_seq_pkg.sv | 37 +++
 rtl/jseq_sync_edge.sv | 32 +++
 rtl/jpeg_frame_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_jpeg_frame_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_seq_pkg.sv
// Shared constants for the JPEG frame sequencer: state encoding, default
// stage timeouts, frame counter width and a small state-class helper.
package jpeg_seq_pkg;

  // Default width of the per-stage timeout counter
  localparam int unsigned TO_W_DEF = 24;

  // Width of the completed-frame counter
  localparam int unsigned FCNT_W = 16;

  // Default timeouts in clk cycles; 0 disables supervision of that stage
  localparam logic [23:0] STAGE_TIMEOUT_DEF = 24'd2_000_000;
  localparam logic [23:0] RD_TIMEOUT_DEF    = 24'd16_000_000;

  // Sequencer state encoding (exported on the debug port)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARM       = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_ENC_START = 3'd3;
  localparam logic [2:0] ST_ENCODE    = 3'd4;
  localparam logic [2:0] ST_READOUT   = 3'd5;
  localparam logic [2:0] ST_ERR       = 3'd6;

  // True for states that wait on an external event and are timed
  function automatic logic is_wait_state(input logic [2:0] st);
    logic res;
    case (st)
      ST_ARM:     res = 1'b1;
      ST_CAPTURE: res = 1'b1;
      ST_ENCODE:  res = 1'b1;
      ST_READOUT: res = 1'b1;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/jseq_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by one more
// flop so a clean single-cycle rising-edge strobe can be derived.
module jseq_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic level,
  output logic rise
);

  // bit0 = first sync stage, bit1 = synchronised level, bit2 = edge history
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw input one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[1:0], d};
  end

  // Synchroniser and edge flops, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/jpeg_frame_sequencer.sv
// Frame scheduler for the OV7670 -> JPEG encoder -> ESP32 SPI pipeline.
// A host request arms capture on the next VSYNC, the encoder is started
// once the capture buffer is full, and the JPEG buffer is held for SPI
// readout until the readout path reports EOF. Every wait is supervised
// by a timeout; a host abort returns to IDLE without flagging an error.
module jpeg_frame_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int unsigned        TO_W          = TO_W_DEF,
  parameter logic [TO_W-1:0]    STAGE_TIMEOUT = STAGE_TIMEOUT_DEF,
  parameter logic [TO_W-1:0]    RD_TIMEOUT    = RD_TIMEOUT_DEF,
  parameter bit                 CONTINUOUS    = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_req,
  input  logic              host_abort,
  input  logic              cam_vsync,
  input  logic              cap_done,
  input  logic              je_done,
  input  logic              rd_eof,
  output logic              cap_en,
  output logic              je_start,
  output logic              spi_go,
  output logic              rd_ready,
  output logic              err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [2:0]        state
);

  localparam logic [TO_W-1:0]   TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   TO_ZERO  = {TO_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

  // Synchronised host / camera inputs
  logic req_lvl_s, req_rise_s;
  logic abort_lvl_s, abort_rise_s;
  logic vsync_lvl_s, vsync_rise_s;

  jseq_sync_edge u_sync_req (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (host_req),
    .level   (req_lvl_s),
    .rise    (req_rise_s)
  );

  jseq_sync_edge u_sync_abort (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (host_abort),
    .level   (abort_lvl_s),
    .rise    (abort_rise_s)
  );

  jseq_sync_edge u_sync_vsync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cam_vsync),
    .level   (vsync_lvl_s),
    .rise    (vsync_rise_s)
  );

  // Only the request edge, abort level and VSYNC edge drive the FSM
  logic unused_sync_s;
  assign unused_sync_s = req_lvl_s ^ abort_rise_s ^ vsync_lvl_s;

  logic [2:0]        state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic              cap_en_q, cap_en_d;
  logic              je_start_q, je_start_d;
  logic              spi_go_q, spi_go_d;
  logic              rd_ready_q, rd_ready_d;

  logic [TO_W-1:0]   limit_s;
  logic              timeout_s;
  logic              eof_accept_s;

  // Pick the active stage limit and flag expiry on its final cycle
  always_comb begin
    if (state_q == ST_READOUT) begin
      limit_s = RD_TIMEOUT;
    end else begin
      limit_s = STAGE_TIMEOUT;
    end
    if ((limit_s != TO_ZERO) && (to_cnt_q == (limit_s - TO_ONE))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state decode: abort beats completion, completion beats timeout
  always_comb begin
    state_d = state_q;
    if (abort_lvl_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((CONTINUOUS == 1'b1) || req_rise_s) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (vsync_rise_s) begin
            state_d = ST_CAPTURE;
          end else if (timeout_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_ARM;
          end
        end
        ST_CAPTURE: begin
          if (cap_done) begin
            state_d = ST_ENC_START;
          end else if (timeout_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_ENC_START: begin
          state_d = ST_ENCODE;
        end
        ST_ENCODE: begin
          if (je_done) begin
            state_d = ST_READOUT;
          end else if (timeout_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_ENCODE;
          end
        end
        ST_READOUT: begin
          if (rd_eof) begin
            if (CONTINUOUS == 1'b1) begin
              state_d = ST_ARM;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (timeout_s) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_READOUT;
          end
        end
        ST_ERR: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Timeout counter restarts on any state change and runs in wait states
  always_comb begin
    if (state_d != state_q) begin
      to_cnt_d = TO_ZERO;
    end else if (is_wait_state(state_q)) begin
      to_cnt_d = to_cnt_q + TO_ONE;
    end else begin
      to_cnt_d = TO_ZERO;
    end
  end

  // Frame completion bookkeeping and the sticky error flag
  always_comb begin
    eof_accept_s = (!abort_lvl_s) && (state_q == ST_READOUT) && rd_eof;
    if (eof_accept_s) begin
      frame_cnt_d = frame_cnt_q + FCNT_ONE;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (state_d == ST_ERR) begin
      err_d = 1'b1;
    end else if (eof_accept_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Registered handshake outputs decoded from the state being entered
  always_comb begin
    cap_en_d   = (state_d == ST_CAPTURE);
    je_start_d = (state_d == ST_ENC_START);
    spi_go_d   = (state_q == ST_ENCODE) && (state_d == ST_READOUT);
    rd_ready_d = (state_d == ST_READOUT);
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      to_cnt_q    <= TO_ZERO;
      frame_cnt_q <= {FCNT_W{1'b0}};
      err_q       <= 1'b0;
      cap_en_q    <= 1'b0;
      je_start_q  <= 1'b0;
      spi_go_q    <= 1'b0;
      rd_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      cap_en_q    <= cap_en_d;
      je_start_q  <= je_start_d;
      spi_go_q    <= spi_go_d;
      rd_ready_q  <= rd_ready_d;
    end
  end

  assign cap_en    = cap_en_q;
  assign je_start  = je_start_q;
  assign spi_go    = spi_go_q;
  assign rd_ready  = rd_ready_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// Directed bench for jpeg_frame_sequencer: instance A runs single-shot
// mode, instance B runs continuous mode. Both use short timeouts
// (16 cycles per stage, 32 for readout).
module tb_jpeg_frame_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  logic a_req, a_abort, a_vsync, a_cap, a_je, a_eof;
  logic a_cap_en, a_je_start, a_spi_go, a_rd_ready, a_err;
  logic [15:0] a_fcnt;
  logic [2:0]  a_state;

  logic b_req, b_abort, b_vsync, b_cap, b_je, b_eof;
  logic b_cap_en, b_je_start, b_spi_go, b_rd_ready, b_err;
  logic [15:0] b_fcnt;
  logic [2:0]  b_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jpeg_frame_sequencer #(
    .TO_W(24), .STAGE_TIMEOUT(24'd16), .RD_TIMEOUT(24'd32), .CONTINUOUS(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .host_req(a_req), .host_abort(a_abort),
    .cam_vsync(a_vsync), .cap_done(a_cap), .je_done(a_je), .rd_eof(a_eof),
    .cap_en(a_cap_en), .je_start(a_je_start), .spi_go(a_spi_go),
    .rd_ready(a_rd_ready), .err(a_err), .frame_cnt(a_fcnt), .state(a_state)
  );

  jpeg_frame_sequencer #(
    .TO_W(24), .STAGE_TIMEOUT(24'd16), .RD_TIMEOUT(24'd32), .CONTINUOUS(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .host_req(b_req), .host_abort(b_abort),
    .cam_vsync(b_vsync), .cap_done(b_cap), .je_done(b_je), .rd_eof(b_eof),
    .cap_en(b_cap_en), .je_start(b_je_start), .spi_go(b_spi_go),
    .rd_ready(b_rd_ready), .err(b_err), .frame_cnt(b_fcnt), .state(b_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive instance A from IDLE through to the first ENCODE cycle
  task automatic a_to_encode();
    a_req = 1'b1;
    repeat (3) step();
    a_req = 1'b0;
    chk("a_arm", {29'd0, a_state}, 32'd1);
    a_vsync = 1'b1;
    repeat (3) step();
    a_vsync = 1'b0;
    chk("a_capture", {29'd0, a_state}, 32'd2);
    a_cap = 1'b1;
    step();
    a_cap = 1'b0;
    step();
    chk("a_encode", {29'd0, a_state}, 32'd4);
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; a_abort = 1'b0; a_vsync = 1'b0; a_cap = 1'b0; a_je = 1'b0; a_eof = 1'b0;
    b_req = 1'b0; b_abort = 1'b1; b_vsync = 1'b0; b_cap = 1'b0; b_je = 1'b0; b_eof = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_outs", {27'd0, a_cap_en, a_je_start, a_spi_go, a_rd_ready, a_err}, 32'd0);
    chk("rst_fcnt", {16'd0, a_fcnt}, 32'd0);
    chk("rst_state", {29'd0, a_state}, 32'd0);
    reset_n = 1'b1;
    repeat (4) step();

    // Nominal frame with request-to-ARM latency of three edges
    a_req = 1'b1;
    step();
    step();
    chk("lat_idle", {29'd0, a_state}, 32'd0);
    step();
    chk("lat_arm", {29'd0, a_state}, 32'd1);
    a_req = 1'b0;
    a_vsync = 1'b1;
    repeat (3) step();
    a_vsync = 1'b0;
    chk("nom_cap_state", {29'd0, a_state}, 32'd2);
    chk("nom_cap_en", {31'd0, a_cap_en}, 32'd1);
    repeat (5) step();
    chk("nom_cap_hold", {31'd0, a_cap_en}, 32'd1);
    a_cap = 1'b1;
    step();
    a_cap = 1'b0;
    chk("nom_encstart", {29'd0, a_state}, 32'd3);
    chk("nom_cap_en_fall", {31'd0, a_cap_en}, 32'd0);
    chk("nom_je_start", {31'd0, a_je_start}, 32'd1);
    step();
    chk("nom_encode", {29'd0, a_state}, 32'd4);
    chk("nom_je_start_off", {31'd0, a_je_start}, 32'd0);
    repeat (3) step();
    a_je = 1'b1;
    step();
    a_je = 1'b0;
    chk("nom_readout", {29'd0, a_state}, 32'd5);
    chk("nom_spi_go", {31'd0, a_spi_go}, 32'd1);
    chk("nom_rd_ready", {31'd0, a_rd_ready}, 32'd1);
    step();
    chk("nom_spi_go_off", {31'd0, a_spi_go}, 32'd0);
    chk("nom_rd_ready_hold", {31'd0, a_rd_ready}, 32'd1);
    a_eof = 1'b1;
    step();
    a_eof = 1'b0;
    chk("nom_idle", {29'd0, a_state}, 32'd0);
    chk("nom_rd_ready_off", {31'd0, a_rd_ready}, 32'd0);
    chk("nom_fcnt", {16'd0, a_fcnt}, 32'd1);
    chk("nom_err", {31'd0, a_err}, 32'd0);

    // Encoder timeout: 16 ENCODE cycles, one ERR cycle, back to IDLE
    a_to_encode();
    repeat (15) step();
    chk("to_last_encode", {29'd0, a_state}, 32'd4);
    step();
    chk("to_err_state", {29'd0, a_state}, 32'd6);
    chk("to_err_flag", {31'd0, a_err}, 32'd1);
    step();
    chk("to_idle", {29'd0, a_state}, 32'd0);
    chk("to_err_sticky", {31'd0, a_err}, 32'd1);
    chk("to_fcnt", {16'd0, a_fcnt}, 32'd1);

    // je_done on the final timeout cycle wins; frame then clears err
    a_to_encode();
    repeat (15) step();
    a_je = 1'b1;
    step();
    a_je = 1'b0;
    chk("sim_readout", {29'd0, a_state}, 32'd5);
    chk("sim_spi_go", {31'd0, a_spi_go}, 32'd1);
    a_eof = 1'b1;
    step();
    a_eof = 1'b0;
    chk("sim_fcnt", {16'd0, a_fcnt}, 32'd2);
    chk("sim_err_clear", {31'd0, a_err}, 32'd0);

    // Abort during CAPTURE
    a_req = 1'b1;
    repeat (3) step();
    a_req = 1'b0;
    a_vsync = 1'b1;
    repeat (3) step();
    a_vsync = 1'b0;
    chk("ab_capture", {29'd0, a_state}, 32'd2);
    a_abort = 1'b1;
    step();
    step();
    chk("ab_not_yet", {29'd0, a_state}, 32'd2);
    step();
    chk("ab_idle", {29'd0, a_state}, 32'd0);
    chk("ab_cap_en", {31'd0, a_cap_en}, 32'd0);
    chk("ab_err", {31'd0, a_err}, 32'd0);
    a_req = 1'b1;
    repeat (4) step();
    chk("ab_hold_idle", {29'd0, a_state}, 32'd0);
    a_abort = 1'b0;
    a_req = 1'b0;
    repeat (4) step();
    chk("ab_after", {29'd0, a_state}, 32'd0);

    // Spurious completion pulses and a second request during READOUT
    a_je = 1'b1; step(); a_je = 1'b0;
    a_eof = 1'b1; step(); a_eof = 1'b0;
    chk("sp_idle", {29'd0, a_state}, 32'd0);
    a_req = 1'b1;
    repeat (3) step();
    a_req = 1'b0;
    a_je = 1'b1; step(); a_je = 1'b0;
    a_eof = 1'b1; step(); a_eof = 1'b0;
    a_cap = 1'b1; step(); a_cap = 1'b0;
    chk("sp_arm", {29'd0, a_state}, 32'd1);
    chk("sp_fcnt_arm", {16'd0, a_fcnt}, 32'd2);
    a_vsync = 1'b1;
    repeat (3) step();
    a_vsync = 1'b0;
    a_cap = 1'b1; step(); a_cap = 1'b0;
    step();
    a_je = 1'b1; step(); a_je = 1'b0;
    a_req = 1'b1;
    repeat (4) step();
    chk("sp_readout", {29'd0, a_state}, 32'd5);
    a_eof = 1'b1; step(); a_eof = 1'b0;
    chk("sp_eof_idle", {29'd0, a_state}, 32'd0);
    repeat (3) step();
    chk("sp_no_queue", {29'd0, a_state}, 32'd0);
    chk("sp_fcnt", {16'd0, a_fcnt}, 32'd3);
    a_req = 1'b0;

    // Continuous mode on instance B: three frames with no host_req
    chk("cont_parked", {29'd0, b_state}, 32'd0);
    b_abort = 1'b0;
    repeat (3) step();
    chk("cont_first_arm", {29'd0, b_state}, 32'd1);
    for (int f = 0; f < 3; f++) begin
      b_vsync = 1'b1;
      repeat (3) step();
      b_vsync = 1'b0;
      b_cap = 1'b1; step(); b_cap = 1'b0;
      step();
      b_je = 1'b1; step(); b_je = 1'b0;
      b_eof = 1'b1; step(); b_eof = 1'b0;
      chk("cont_rearm", {29'd0, b_state}, 32'd1);
      chk("cont_fcnt", {16'd0, b_fcnt}, f + 1);
    end
    chk("cont_err", {31'd0, b_err}, 32'd0);
    b_abort = 1'b1;
    repeat (3) step();
    chk("cont_abort_idle", {29'd0, b_state}, 32'd0);

    // Reset while in READOUT
    a_to_encode();
    a_je = 1'b1; step(); a_je = 1'b0;
    chk("rr_rd_ready", {31'd0, a_rd_ready}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rr_outs", {27'd0, a_cap_en, a_je_start, a_spi_go, a_rd_ready, a_err}, 32'd0);
    chk("rr_state", {29'd0, a_state}, 32'd0);
    chk("rr_fcnt", {16'd0, a_fcnt}, 32'd0);
    chk("rr_b_fcnt", {16'd0, b_fcnt}, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (3) step();

    // Frame counter wrap
    force dut_a.frame_cnt_q = 16'hFFFF;
    step();
    step();
    release dut_a.frame_cnt_q;
    step();
    chk("wrap_pre", {16'd0, a_fcnt}, 32'h0000FFFF);
    a_to_encode();
    a_je = 1'b1; step(); a_je = 1'b0;
    a_eof = 1'b1; step(); a_eof = 1'b0;
    chk("wrap_fcnt", {16'd0, a_fcnt}, 32'd0);
    chk("wrap_idle", {29'd0, a_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
